jtag_debug_ctrl: RTL and testbench

// - Command sequencer behind JtagPort. Decodes each completed scan (instrLine/dataLine + doUpdate pulse).
// - Runs debug memory reads/writes, halt, resume and single-step on the core.
// - Arbitrates the single memory bus between the core and JTAG debug accesses.
// - Read results are returned on jtagRdData for the next capture.

---
 rtl/jtag_debug_ctrl.sv | 106 ++++++++++
 tb/tb_jtag_debug_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtag_debug_ctrl.sv
// jtag_debug_ctrl: JTAG debug command sequencer and core/JTAG memory bus arbiter.
// Define JTAG_AUTOINC_EN to post-increment the debug address after each successful access.
module jtag_debug_ctrl #(
    parameter int ACK_TIMEOUT   = 16,
    parameter bit HALT_ON_RESET = 1'b0
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        doUpdate,
    input  logic [7:0]  instrLine,
    input  logic [15:0] dataLine,
    output logic [15:0] jtagRdData,
    output logic        jtagBusy,
    output logic        stsErr,
    output logic        coreHalt,
    output logic        coreStep,
    input  logic        coreReq,
    input  logic        coreWr,
    input  logic [15:0] coreAddr,
    input  logic [15:0] coreWrData,
    output logic [15:0] coreRdData,
    output logic        coreAck,
    output logic        memReq,
    output logic        memWr,
    output logic [15:0] memAddr,
    output logic [15:0] memWrData,
    input  logic [15:0] memRdData,
    input  logic        memAck
);
    localparam logic [7:0] OP_SET_ADDR = 8'h01;
    localparam logic [7:0] OP_WRITE    = 8'h02;
    localparam logic [7:0] OP_READ     = 8'h03;
    localparam logic [7:0] OP_HALT     = 8'h04;
    localparam logic [7:0] OP_RESUME   = 8'h05;
    localparam logic [7:0] OP_STEP     = 8'h06;
    localparam logic [7:0] OP_CLR_ERR  = 8'h07;
    localparam int TW = $clog2(ACK_TIMEOUT + 1);
    typedef enum logic [1:0] {IDLE, GRANT_WAIT, JACCESS, DONE} state_t;
    state_t state, state_nx;
    logic owner_jtag, op_wr;
    logic [15:0] addr, operand;
    logic [TW-1:0] tcnt;
    logic idle_cmd, mem_cmd, grant, acked, timeout, err_set;
    always_comb begin
        idle_cmd = doUpdate && state == IDLE;
        mem_cmd  = idle_cmd && (instrLine == OP_WRITE || instrLine == OP_READ);
        grant    = !coreReq || memAck;
        acked    = state == JACCESS && memAck;
        timeout  = state == JACCESS && !memAck && tcnt == TW'(ACK_TIMEOUT - 1);
        err_set  = (idle_cmd && instrLine > OP_CLR_ERR) || (doUpdate && state != IDLE) || timeout;
    end
    always_ff @(posedge clk or negedge rstn)
        if (!rstn) state <= IDLE;
        else       state <= state_nx;
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:       state_nx = mem_cmd ? GRANT_WAIT : IDLE;
            GRANT_WAIT: state_nx = grant ? JACCESS : GRANT_WAIT;
            JACCESS:    state_nx = (acked || timeout) ? DONE : JACCESS;
            default:    state_nx = IDLE;
        endcase
    end
    // Core owns the bus by default; it is simply passed through.
    always_comb begin
        memReq     = owner_jtag ? state == JACCESS : coreReq;
        memWr      = owner_jtag ? op_wr : coreWr;
        memAddr    = owner_jtag ? addr : coreAddr;
        memWrData  = owner_jtag ? operand : coreWrData;
        coreAck    = owner_jtag ? 1'b0 : memAck;
        coreRdData = memRdData;
        jtagBusy   = state != IDLE;
    end
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            jtagRdData <= '0;
            addr       <= '0;
            operand    <= '0;
            op_wr      <= 1'b0;
            stsErr     <= 1'b0;
            coreHalt   <= HALT_ON_RESET;
            coreStep   <= 1'b0;
            owner_jtag <= 1'b0;
            tcnt       <= '0;
        end else begin
            coreStep <= idle_cmd && instrLine == OP_STEP && coreHalt;
            stsErr   <= err_set || (stsErr && !(idle_cmd && instrLine == OP_CLR_ERR));
            tcnt     <= state == JACCESS ? tcnt + 1'b1 : '0;
            if (idle_cmd && instrLine == OP_SET_ADDR) addr <= dataLine;
            if (idle_cmd && instrLine == OP_HALT) coreHalt <= 1'b1;
            if (idle_cmd && instrLine == OP_RESUME) coreHalt <= 1'b0;
            if (mem_cmd) begin
                operand <= dataLine;
                op_wr   <= instrLine == OP_WRITE;
            end
            if (state == GRANT_WAIT && grant) owner_jtag <= 1'b1;
            if (state == DONE) owner_jtag <= 1'b0;
            if (acked && !op_wr) jtagRdData <= memRdData;
`ifdef JTAG_AUTOINC_EN
            if (acked) addr <= addr + 16'd1;
`else
            if (acked) addr <= addr;
`endif
        end
    end
endmodule

// File: tb/tb_jtag_debug_ctrl.sv
// tb_jtag_debug_ctrl: randomized and directed checks of jtag_debug_ctrl against a command-level model.
module tb_jtag_debug_ctrl;
    logic        clk = 1'b0, rstn = 1'b0, doUpdate = 1'b0;
    logic [7:0]  instrLine = '0;
    logic [15:0] dataLine = '0;
    logic [15:0] jtagRdData, coreRdData, memAddr, memWrData;
    logic        jtagBusy, stsErr, coreHalt, coreStep, coreAck, memReq, memWr;
    logic        coreReq = 1'b0, coreWr = 1'b0, memAck = 1'b0;
    logic [15:0] coreAddr = '0, coreWrData = '0, memRdData = '0;

    jtag_debug_ctrl #(.ACK_TIMEOUT(16), .HALT_ON_RESET(1'b0)) dut (
        .clk(clk), .rstn(rstn), .doUpdate(doUpdate), .instrLine(instrLine), .dataLine(dataLine),
        .jtagRdData(jtagRdData), .jtagBusy(jtagBusy), .stsErr(stsErr), .coreHalt(coreHalt),
        .coreStep(coreStep), .coreReq(coreReq), .coreWr(coreWr), .coreAddr(coreAddr),
        .coreWrData(coreWrData), .coreRdData(coreRdData), .coreAck(coreAck), .memReq(memReq),
        .memWr(memWr), .memAddr(memAddr), .memWrData(memWrData), .memRdData(memRdData),
        .memAck(memAck)
    );

    always #5 clk = ~clk;

    int tests = 0, fails = 0;
    logic [15:0] mem [0:65535];
    logic [15:0] ref_mem [0:65535];
    logic [15:0] wlog_a [$];
    logic [15:0] wlog_d [$];
    int ack_delay = 0, wait_cnt = 0, step_cnt = 0;
    bit ack_never = 0;
    logic [15:0] exp_addr = '0, exp_rd = '0, last_wa = '0;
    logic exp_err = 1'b0, exp_halt = 1'b0;

    // Memory slave: acks after ack_delay waiting cycles, one-cycle ack pulse.
    initial forever begin
        @(posedge clk);
        #2;
        if (memAck) memAck = 1'b0;
        else if (memReq && !ack_never) begin
            if (wait_cnt >= ack_delay) begin
                memAck = 1'b1;
                memRdData = mem[memAddr];
                if (memWr) begin
                    mem[memAddr] = memWrData;
                    wlog_a.push_back(memAddr);
                    wlog_d.push_back(memWrData);
                end
                wait_cnt = 0;
            end else wait_cnt++;
        end else wait_cnt = 0;
    end

    always @(negedge clk) if (coreStep) step_cnt++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model(input logic [7:0] op, input logic [15:0] d);
        case (op)
            8'h00, 8'h06: ;
            8'h01: exp_addr = d;
            8'h02: begin
                ref_mem[exp_addr] = d;
`ifdef JTAG_AUTOINC_EN
                exp_addr = exp_addr + 16'd1;
`endif
            end
            8'h03: begin
                exp_rd = ref_mem[exp_addr];
`ifdef JTAG_AUTOINC_EN
                exp_addr = exp_addr + 16'd1;
`endif
            end
            8'h04: exp_halt = 1'b1;
            8'h05: exp_halt = 1'b0;
            8'h07: exp_err = 1'b0;
            default: exp_err = 1'b1;
        endcase
    endtask

    task automatic issue(input logic [7:0] op, input logic [15:0] d);
        @(negedge clk);
        doUpdate = 1'b1;
        instrLine = op;
        dataLine = d;
        @(negedge clk);
        doUpdate = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (jtagBusy && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("idle", jtagBusy, 0);
    endtask

    task automatic chk_wlog(input logic [15:0] a, input logic [15:0] d);
        chk("wlog_n", wlog_a.size(), 1);
        if (wlog_a.size() > 0) begin
            last_wa = wlog_a.pop_front();
            chk("wr_addr", last_wa, a);
            chk("wr_data", wlog_d.pop_front(), d);
        end
    endtask

    task automatic run(input logic [7:0] op, input logic [15:0] d);
        logic [15:0] a;
        a = exp_addr;
        model(op, d);
        issue(op, d);
        wait_idle();
        if (op == 8'h02) chk_wlog(a, d);
        else chk("no_write", wlog_a.size(), 0);
        chk("rd_data", jtagRdData, exp_rd);
        chk("sts_err", stsErr, exp_err);
        chk("core_halt", coreHalt, exp_halt);
    endtask

    initial begin
        logic [15:0] a, d, rd0;
        int hi, n, core_ack_at, jreq_at, base;
        bit bad;
        for (int i = 0; i < 65536; i++) begin
            mem[i] = 16'($urandom());
            ref_mem[i] = mem[i];
        end
        repeat (3) @(negedge clk);
        chk("rst_rd", jtagRdData, 0);
        chk("rst_err", stsErr, 0);
        chk("rst_halt", coreHalt, 0);
        chk("rst_step", coreStep, 0);
        chk("rst_req", memReq, 0);
        chk("rst_busy", jtagBusy, 0);
        rstn = 1'b1;

        // Basic write/read with latency checks on the write
        run(8'h01, 16'h0040);
        a = exp_addr;
        model(8'h02, 16'hBEEF);
        issue(8'h02, 16'hBEEF);
        chk("lat_req0", memReq, 0);
        chk("lat_busy0", jtagBusy, 1);
        @(negedge clk);
        chk("lat_req1", {memReq, memWr, memAddr, memWrData}, {1'b1, 1'b1, 16'h0040, 16'hBEEF});
        @(negedge clk);
        chk("lat_done_req", memReq, 0);
        chk("lat_done_busy", jtagBusy, 1);
        @(negedge clk);
        chk("lat_idle", jtagBusy, 0);
        chk_wlog(a, 16'hBEEF);
        run(8'h01, 16'h0040);
        run(8'h03, 16'h0000);
        chk("beef_rd", jtagRdData, 16'hBEEF);
        chk("beef_err", stsErr, 0);

        // Randomized command stream
        for (int i = 0; i < 30; i++) begin
            ack_delay = $urandom_range(0, 4);
            run(8'($urandom_range(0, 5)), 16'($urandom()));
        end
        run(8'h05, 16'h0000);

        // Arbitration: core request pending when JTAG read arrives
        run(8'h01, 16'h0200);
        ack_delay = 3;
        @(negedge clk);
        coreReq = 1'b1;
        coreWr = 1'b0;
        coreAddr = 16'h1234;
        model(8'h03, 16'h0000);
        issue(8'h03, 16'h0000);
        n = 0; core_ack_at = -1; jreq_at = -1; bad = 0;
        while (jtagBusy && n < 100) begin
            if (coreAck && core_ack_at >= 0 && n > core_ack_at) bad = 1;
            if (coreAck && core_ack_at < 0) core_ack_at = n;
            if (memReq && memAddr == 16'h0200 && jreq_at < 0) jreq_at = n;
            @(negedge clk);
            n++;
        end
        coreReq = 1'b0;
        chk("arb_core_ack_seen", core_ack_at >= 0, 1);
        chk("arb_jtag_after_core", jreq_at > core_ack_at, 1);
        chk("arb_no_core_ack", bad, 0);
        chk("arb_idle", jtagBusy, 0);
        chk("arb_rd", jtagRdData, exp_rd);
        repeat (3) @(negedge clk);
        ack_delay = 0;

        // Halt / step / resume
        base = step_cnt;
        run(8'h04, 16'h0000);
        chk("halt_set", coreHalt, 1);
        for (int k = 0; k < 2; k++) begin
            issue(8'h06, 16'h0000);
            chk("step_hi", coreStep, 1);
            @(negedge clk);
            chk("step_lo", coreStep, 0);
        end
        run(8'h05, 16'h0000);
        chk("halt_clr", coreHalt, 0);
        issue(8'h06, 16'h0000);
        chk("step_ignored", coreStep, 0);
        repeat (2) @(negedge clk);
        chk("step_count", step_cnt - base, 2);
        chk("step_no_err", stsErr, 0);

        // Ack timeout
        ack_never = 1;
        rd0 = exp_rd;
        issue(8'h03, 16'h0000);
        hi = 0;
        n = 0;
        while (n < 100) begin
            @(negedge clk);
            n++;
            if (memReq) hi++;
            else if (hi > 0) break;
        end
        chk("to_req_cycles", hi, 16);
        exp_err = 1'b1;
        wait_idle();
        chk("to_err", stsErr, 1);
        chk("to_rd_kept", jtagRdData, rd0);
        ack_never = 0;
        run(8'h07, 16'h0000);
        chk("to_clr", stsErr, 0);
        run(8'h02, 16'($urandom()));

        // Overrun during JACCESS
        ack_delay = 5;
        a = exp_addr;
        d = 16'($urandom());
        model(8'h02, d);
        issue(8'h02, d);
        @(negedge clk);
        doUpdate = 1'b1;
        instrLine = 8'h04;
        @(negedge clk);
        doUpdate = 1'b0;
        exp_err = 1'b1;
        wait_idle();
        chk("ovr_err", stsErr, 1);
        chk("ovr_halt", coreHalt, 0);
        chk_wlog(a, d);
        run(8'h07, 16'h0000);
        run(8'h3A, 16'($urandom()));
        chk("bad_op_err", stsErr, 1);
        run(8'h07, 16'h0000);

        // Overrun in the DONE cycle
        ack_delay = 0;
        a = exp_addr;
        d = 16'($urandom());
        model(8'h02, d);
        issue(8'h02, d);
        @(negedge clk);
        @(negedge clk);
        doUpdate = 1'b1;
        instrLine = 8'h04;
        @(negedge clk);
        doUpdate = 1'b0;
        exp_err = 1'b1;
        wait_idle();
        chk("done_ovr_err", stsErr, 1);
        chk("done_ovr_halt", coreHalt, 0);
        chk_wlog(a, d);
        run(8'h07, 16'h0000);

        // Address wrap
        run(8'h01, 16'hFFFF);
        run(8'h02, 16'h0001);
        chk("wrap_first", last_wa, 16'hFFFF);
        run(8'h02, 16'h0002);
`ifdef JTAG_AUTOINC_EN
        chk("wrap_second", last_wa, 16'h0000);
`else
        chk("wrap_second", last_wa, 16'hFFFF);
`endif

        // Asynchronous reset mid-transaction
        run(8'h04, 16'h0000);
        ack_never = 1;
        issue(8'h03, 16'h0000);
        @(negedge clk);
        chk("arst_pre_req", memReq, 1);
        #2 rstn = 1'b0;
        #1;
        chk("arst_req", memReq, 0);
        chk("arst_busy", jtagBusy, 0);
        chk("arst_rd", jtagRdData, 0);
        chk("arst_halt", coreHalt, 0);
        chk("arst_err", stsErr, 0);
        @(negedge clk);
        rstn = 1'b1;
        ack_never = 0;
        exp_addr = '0; exp_rd = '0; exp_err = 1'b0; exp_halt = 1'b0;
        run(8'h03, 16'h0000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
